mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single word-addressed CPU memory port (valid/ready request, 4-bit byte-write mask, reads answered by `resp_valid` one or more cycles later, writes unanswered) between two requesters.
- Requester I is instruction fetch. Requester D is load/store.
- Sits between the CPU pipeline and the no-cache main memory.
- Round-robin arbitration, an in-order owner FIFO for routing read responses, and detection of unexpected responses.

Parameters:
- CPU_WIDTH, 32 — data width of each port.
- WORD_ADDR_BITS, 30 — word address width (`CPU_ADDR_BITS` minus `log2(CPU_WIDTH/8)`).
- MAX_OUTSTANDING, 2 — owner FIFO depth, i.e. the number of reads in flight; power of two, ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (state clears on a clk edge while reset=0).
- i_req_valid  in  1  fetch request valid.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_req_addr  in  WORD_ADDR_BITS  fetch word address.
- i_req_data  in  CPU_WIDTH  fetch write data; normally unused.
- i_req_write  in  4  fetch byte-write mask; 0 means read.
- i_resp_valid  out  1  fetch read data valid.
- i_resp_data  out  CPU_WIDTH  fetch read data.
- d_req_valid, d_req_ready, d_req_addr, d_req_data, d_req_write, d_resp_valid, d_resp_data: same as the i_* ports, for load/store.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  WORD_ADDR_BITS  muxed address.
- mem_req_data  out  CPU_WIDTH  muxed write data.
- mem_req_write  out  4  muxed byte mask.
- mem_resp_valid  in  1  memory read data valid.
- mem_resp_data  in  CPU_WIDTH  memory read data.
- err_orphan_resp  out  1  sticky flag: a response arrived with no outstanding read.

Behaviour:

Classification
- A request is a read when `req_write == 4'b0000`, otherwise a write.

Grant (combinational)
- Only one valid requester: it is the candidate.
- Both valid: the candidate is the one not recorded in `last_grant`.
- Neither valid: no candidate; `mem_req_valid=0`.

Eligibility and muxing
- A read candidate is eligible only if the FIFO is not full, or a pop happens in the same cycle (`mem_resp_valid=1`). A write is always eligible.
- `mem_req_valid` = candidate exists and is eligible. `mem_req_addr/data/write` are muxed from the candidate. When no request is presented, the muxed outputs are don't-care but must be driven to 0.
- `x_req_ready` = (x is the candidate) & eligible & `mem_req_ready`. The non-candidate's ready is 0.
- No combinational path from `x_req_valid` to `x_req_ready` of the same port except through the grant mux.

Fire and grant state
- fire = `mem_req_valid & mem_req_ready`.
- On fire, `last_grant` <= granted port. `last_grant` is unchanged if nothing fires.

Owner FIFO
- Read fire: push the owner bit (0=I, 1=D).
- `mem_resp_valid` with FIFO non-empty: pop.
- Push and pop in the same cycle are allowed, including when the FIFO is full (the eligibility rule covers this) or empty (the pushed entry is not the one popped).
- Occupancy never exceeds MAX_OUTSTANDING; pointers wrap modulo depth.

Response routing (combinational, zero added latency)
- `i_resp_valid = mem_resp_valid & !empty & head==I`; `d_resp_valid` likewise for head==D.
- Both `resp_data` outputs = `mem_resp_data`, unmasked.
- Responses return in request order; the memory port is in-order.

Orphan responses
- `mem_resp_valid` with an empty FIFO: the response is dropped (neither port's `resp_valid` asserts).
- `err_orphan_resp` <= 1 and holds until reset.

Ordering
- Requests reach memory in fire order, so a D write followed by an I read of the same address sees the new data.

Fairness
- A continuously valid requester waits at most one grant while the other side holds `mem_req_ready`.

Reset (reset=0 at an edge)
- FIFO emptied, `last_grant`=D (I wins the first tie), `err_orphan_resp`=0.
- Consequently all `resp_valid` outputs are 0.
- Reset mid-transaction discards in-flight ownership; the memory is reset concurrently by the same signal.

Decomposition:
- Shared package/header: `OWNER_I`/`OWNER_D` encoding constants, `READ_MASK=4'b0000`.
- Sub-module `owner_fifo`: parameterised width/depth, synchronous active-low reset, push/pop/full/empty, simultaneous push+pop supported.
- The arbiter keeps the grant logic, `last_grant` register, muxes and error flag.

Test Plan:
- Reset held 2 cycles then released, no requests → all ready/resp_valid=0, `err_orphan_resp`=0, `mem_req_valid`=0.
- Only I reads addr 0x10, memory returns 0xDEADBEEF next cycle → `i_resp_valid`=1 with 0xDEADBEEF one cycle after fire; `d_resp_valid` stays 0.
- I and D both read continuously (I addr 0x4, D addr 0x8) → grants alternate I, D, I, D starting with I; responses routed to the matching port every cycle.
- D write mask 4'b0011 data 0x0000ABCD to 0x20, then I read 0x20 → no FIFO push for the write; I receives the updated word with its low half = 0xABCD.
- `mem_req_ready` held 0 for 5 cycles with both valid → no fire, `last_grant` unchanged, both ready 0; on release the previously pending winner fires first.
- With MAX_OUTSTANDING=2 and the memory stalling responses, issue 2 reads → 3rd read blocked (ready=0) until a response arrives, then accepted the same cycle; inject `mem_resp_valid` with the FIFO empty → `err_orphan_resp`=1 and sticky.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-requester memory port arbiter.
// Owner bits route read responses; READ_MASK marks a read request.
package mem_port_arbiter_pkg;

  localparam logic       OWNER_I   = 1'b0;
  localparam logic       OWNER_D   = 1'b1;
  localparam logic [3:0] READ_MASK = 4'b0000;

endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// In-order owner FIFO: one entry per read in flight.
// Push and pop may coincide, including at full and empty.
module owner_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = inc(wr_q);
    end
    if (do_pop) begin
      rd_d = inc(rd_q);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one memory port between fetch (I) and
// load/store (D), with in-order read response routing.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int CPU_WIDTH       = 32,
  parameter int WORD_ADDR_BITS  = 30,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_req_valid,
  output logic                      i_req_ready,
  input  logic [WORD_ADDR_BITS-1:0] i_req_addr,
  input  logic [CPU_WIDTH-1:0]      i_req_data,
  input  logic [3:0]                i_req_write,
  output logic                      i_resp_valid,
  output logic [CPU_WIDTH-1:0]      i_resp_data,
  input  logic                      d_req_valid,
  output logic                      d_req_ready,
  input  logic [WORD_ADDR_BITS-1:0] d_req_addr,
  input  logic [CPU_WIDTH-1:0]      d_req_data,
  input  logic [3:0]                d_req_write,
  output logic                      d_resp_valid,
  output logic [CPU_WIDTH-1:0]      d_resp_data,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [WORD_ADDR_BITS-1:0] mem_req_addr,
  output logic [CPU_WIDTH-1:0]      mem_req_data,
  output logic [3:0]                mem_req_write,
  input  logic                      mem_resp_valid,
  input  logic [CPU_WIDTH-1:0]      mem_resp_data,
  output logic                      err_orphan_resp
);

  logic last_grant_q, last_grant_d;
  logic err_q, err_d;
  logic cand_valid;
  logic cand;
  logic cand_rd;
  logic eligible;
  logic fire;
  logic push;
  logic pop;
  logic head;
  logic full;
  logic empty;

  assign pop = mem_resp_valid & ~empty;

  always_comb begin
    cand_valid = i_req_valid | d_req_valid;
    cand       = OWNER_I;
    if (i_req_valid & d_req_valid) begin
      cand = (last_grant_q == OWNER_D) ? OWNER_I : OWNER_D;
    end else if (d_req_valid) begin
      cand = OWNER_D;
    end
    cand_rd = (cand == OWNER_D) ? (d_req_write == READ_MASK)
                                : (i_req_write == READ_MASK);
  end

  // A read needs a free owner slot, or one freed by this cycle's response.
  assign eligible      = ~cand_rd | ~full | pop;
  assign mem_req_valid = cand_valid & eligible;
  assign fire          = mem_req_valid & mem_req_ready;
  assign push          = fire & cand_rd;

  assign i_req_ready = fire & (cand == OWNER_I);
  assign d_req_ready = fire & (cand == OWNER_D);

  always_comb begin
    mem_req_addr  = '0;
    mem_req_data  = '0;
    mem_req_write = '0;
    if (cand_valid) begin
      if (cand == OWNER_D) begin
        mem_req_addr  = d_req_addr;
        mem_req_data  = d_req_data;
        mem_req_write = d_req_write;
      end else begin
        mem_req_addr  = i_req_addr;
        mem_req_data  = i_req_data;
        mem_req_write = i_req_write;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    err_d        = err_q | (mem_resp_valid & empty);
    if (fire) begin
      last_grant_d = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= OWNER_D;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  owner_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (cand),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign i_resp_valid    = pop & (head == OWNER_I);
  assign d_resp_valid    = pop & (head == OWNER_D);
  assign i_resp_data     = mem_resp_data;
  assign d_resp_data     = mem_resp_data;
  assign err_orphan_resp = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed checks of mem_port_arbiter against a
// queue-based model of ownership, grant history and memory.
module tb_mem_port_arbiter;

  localparam int MAXO = 2;

  logic        clk;
  logic        reset;
  logic        i_req_valid, i_req_ready;
  logic [29:0] i_req_addr;
  logic [31:0] i_req_data;
  logic [3:0]  i_req_write;
  logic        i_resp_valid;
  logic [31:0] i_resp_data;
  logic        d_req_valid, d_req_ready;
  logic [29:0] d_req_addr;
  logic [31:0] d_req_data;
  logic [3:0]  d_req_write;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        mem_req_valid, mem_req_ready;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_write;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        err_orphan_resp;

  mem_port_arbiter #(
    .CPU_WIDTH       (32),
    .WORD_ADDR_BITS  (30),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_req_valid     (i_req_valid),
    .i_req_ready     (i_req_ready),
    .i_req_addr      (i_req_addr),
    .i_req_data      (i_req_data),
    .i_req_write     (i_req_write),
    .i_resp_valid    (i_resp_valid),
    .i_resp_data     (i_resp_data),
    .d_req_valid     (d_req_valid),
    .d_req_ready     (d_req_ready),
    .d_req_addr      (d_req_addr),
    .d_req_data      (d_req_data),
    .d_req_write     (d_req_write),
    .d_resp_valid    (d_resp_valid),
    .d_resp_data     (d_resp_data),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_req_data    (mem_req_data),
    .mem_req_write   (mem_req_write),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .err_orphan_resp (err_orphan_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: owners of reads in flight, last winner, sticky error.
  bit          oq[$];
  bit          lg;
  bit          err_m;
  // Environment memory: contents and read data awaiting return.
  logic [31:0] mem [logic [29:0]];
  logic [31:0] pend[$];
  bit          rsp_en;
  bit          orphan;
  bit          cmp_on;
  bit          e_fire, e_c, e_rd;

  function automatic logic [31:0] mrd(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return {2'b00, a} ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_check();
    bit has, c, rd, elig, mv, hd_ok;
    has   = i_req_valid || d_req_valid;
    // Tie goes to whoever did not win last; else the lone requester.
    c     = (i_req_valid && d_req_valid) ? !lg : d_req_valid;
    rd    = ((c ? d_req_write : i_req_write) == 4'b0000);
    elig  = !rd || (oq.size() < MAXO) || (mem_resp_valid && oq.size() > 0);
    mv    = has && elig;
    hd_ok = mem_resp_valid && oq.size() > 0;
    chk("mem_req_valid", 32'(mem_req_valid), 32'(mv));
    chk("mem_req_addr", 32'(mem_req_addr),
        has ? 32'(c ? d_req_addr : i_req_addr) : 32'd0);
    chk("mem_req_data", mem_req_data,
        has ? (c ? d_req_data : i_req_data) : 32'd0);
    chk("mem_req_write", 32'(mem_req_write),
        has ? 32'(c ? d_req_write : i_req_write) : 32'd0);
    chk("i_req_ready", 32'(i_req_ready), 32'(mv && mem_req_ready && !c));
    chk("d_req_ready", 32'(d_req_ready), 32'(mv && mem_req_ready && c));
    chk("i_resp_valid", 32'(i_resp_valid), 32'(hd_ok && oq[0] == 1'b0));
    chk("d_resp_valid", 32'(d_resp_valid), 32'(hd_ok && oq[0] == 1'b1));
    chk("i_resp_data", i_resp_data, mem_resp_data);
    chk("d_resp_data", d_resp_data, mem_resp_data);
    chk("err_orphan", 32'(err_orphan_resp), 32'(err_m));
    e_fire = mv && mem_req_ready;
    e_c    = c;
    e_rd   = rd;
  endtask

  task automatic drive(
    input bit iv, input logic [29:0] ia, input logic [3:0] iw,
    input logic [31:0] idt,
    input bit dv, input logic [29:0] da, input logic [3:0] dw,
    input logic [31:0] ddt,
    input bit mrdy
  );
    @(negedge clk);
    i_req_valid   = iv;
    i_req_addr    = ia;
    i_req_write   = iw;
    i_req_data    = idt;
    d_req_valid   = dv;
    d_req_addr    = da;
    d_req_write   = dw;
    d_req_data    = ddt;
    mem_req_ready = mrdy;
    if (orphan) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = $urandom;
    end else if (rsp_en && pend.size() > 0) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = pend[0];
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = $urandom;
    end
    #1;
    if (cmp_on) model_check();
  endtask

  task automatic idle(input bit mrdy);
    drive(0, 30'd0, 4'd0, 32'd0, 0, 30'd0, 4'd0, 32'd0, mrdy);
  endtask

  task automatic advance();
    logic [31:0] w;
    if (!reset) begin
      oq.delete();
      pend.delete();
      lg    = 1'b1;
      err_m = 1'b0;
    end else begin
      if (mem_resp_valid) begin
        if (oq.size() > 0) void'(oq.pop_front());
        else err_m = 1'b1;
        if (pend.size() > 0) void'(pend.pop_front());
      end
      if (e_fire) begin
        if (e_rd) oq.push_back(e_c);
        lg = e_c;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (mem_req_write == 4'b0000) begin
          pend.push_back(mrd(mem_req_addr));
        end else begin
          w = mrd(mem_req_addr);
          for (int b = 0; b < 4; b++)
            if (mem_req_write[b]) w[8*b +: 8] = mem_req_data[8*b +: 8];
          mem[mem_req_addr] = w;
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    cmp_on = 1'b0;
    rsp_en = 1'b0;
    orphan = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(1'b0);
    advance();
    idle(1'b0);
    advance();
    #1 reset = 1'b1;
    cmp_on = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    {i_req_valid, i_req_addr, i_req_data, i_req_write} = '0;
    {d_req_valid, d_req_addr, d_req_data, d_req_write} = '0;
    {mem_req_ready, mem_resp_valid, mem_resp_data} = '0;
    e_fire = 0; e_c = 0; e_rd = 0;

    do_reset();
    idle(1'b1);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_i_ready", 32'(i_req_ready), 32'd0);
    chk("rst_d_ready", 32'(d_req_ready), 32'd0);
    chk("rst_i_resp", 32'(i_resp_valid), 32'd0);
    chk("rst_d_resp", 32'(d_resp_valid), 32'd0);
    chk("rst_err", 32'(err_orphan_resp), 32'd0);
    advance();

    mem[30'h10] = 32'hDEAD_BEEF;
    drive(1, 30'h10, 4'd0, 32'd0, 0, 30'd0, 4'd0, 32'd0, 1);
    chk("i1_ready", 32'(i_req_ready), 32'd1);
    chk("i1_addr", 32'(mem_req_addr), 32'h10);
    advance();
    rsp_en = 1'b1;
    idle(1'b1);
    chk("i1_resp_valid", 32'(i_resp_valid), 32'd1);
    chk("i1_resp_data", i_resp_data, 32'hDEAD_BEEF);
    chk("i1_d_resp", 32'(d_resp_valid), 32'd0);
    advance();

    do_reset();
    rsp_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1, 30'h4, 4'd0, $urandom, 1, 30'h8, 4'd0, $urandom, 1);
      chk("alt_i_ready", 32'(i_req_ready), 32'(k % 2 == 0));
      chk("alt_d_ready", 32'(d_req_ready), 32'(k % 2 == 1));
      if (k > 0) chk("alt_i_resp", 32'(i_resp_valid), 32'(k % 2 == 1));
      advance();
    end
    idle(1'b1);
    advance();

    mem[30'h20] = 32'h5566_7788;
    rsp_en = 1'b0;
    drive(0, 30'd0, 4'd0, 32'd0, 1, 30'h20, 4'b0011, 32'h0000_ABCD, 1);
    chk("wr_d_ready", 32'(d_req_ready), 32'd1);
    chk("wr_mask", 32'(mem_req_write), 32'h3);
    advance();
    drive(1, 30'h20, 4'd0, 32'd0, 0, 30'd0, 4'd0, 32'd0, 1);
    chk("rd_after_wr_ready", 32'(i_req_ready), 32'd1);
    advance();
    rsp_en = 1'b1;
    idle(1'b1);
    chk("rd_after_wr_data", i_resp_data, 32'h5566_ABCD);
    chk("rd_after_wr_valid", 32'(i_resp_valid), 32'd1);
    advance();

    rsp_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 30'h1, 4'hF, 32'h1, 1, 30'h2, 4'hF, 32'h2, 0);
      chk("stall_i_ready", 32'(i_req_ready), 32'd0);
      chk("stall_d_ready", 32'(d_req_ready), 32'd0);
      advance();
    end
    drive(1, 30'h1, 4'hF, 32'h1, 1, 30'h2, 4'hF, 32'h2, 1);
    chk("release_d_first", 32'(d_req_ready), 32'd1);
    advance();
    drive(1, 30'h1, 4'hF, 32'h1, 1, 30'h2, 4'hF, 32'h2, 1);
    chk("release_then_i", 32'(i_req_ready), 32'd1);
    advance();

    for (int k = 0; k < 2; k++) begin
      drive(1, 30'h30 + 30'(k), 4'd0, 32'd0, 0, 30'd0, 4'd0, 32'd0, 1);
      chk("fill_ready", 32'(i_req_ready), 32'd1);
      advance();
    end
    drive(1, 30'h32, 4'd0, 32'd0, 0, 30'd0, 4'd0, 32'd0, 1);
    chk("full_blocked", 32'(i_req_ready), 32'd0);
    chk("full_no_valid", 32'(mem_req_valid), 32'd0);
    advance();
    rsp_en = 1'b1;
    drive(1, 30'h32, 4'd0, 32'd0, 0, 30'd0, 4'd0, 32'd0, 1);
    chk("full_pop_accept", 32'(i_req_ready), 32'd1);
    chk("full_pop_resp", 32'(i_resp_valid), 32'd1);
    advance();
    idle(1'b1);
    advance();
    idle(1'b1);
    advance();

    rsp_en = 1'b0;
    orphan = 1'b1;
    idle(1'b1);
    chk("orphan_i_resp", 32'(i_resp_valid), 32'd0);
    chk("orphan_d_resp", 32'(d_resp_valid), 32'd0);
    advance();
    orphan = 1'b0;
    idle(1'b1);
    chk("orphan_err_set", 32'(err_orphan_resp), 32'd1);
    advance();
    idle(1'b1);
    chk("orphan_err_sticky", 32'(err_orphan_resp), 32'd1);
    advance();
    do_reset();
    idle(1'b1);
    chk("err_cleared", 32'(err_orphan_resp), 32'd0);
    advance();

    for (int n = 0; n < 3000; n++) begin
      rsp_en = ($urandom_range(0, 1) == 1);
      orphan = (pend.size() == 0) && ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) < 6, 30'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom),
            $urandom,
            $urandom_range(0, 9) < 6, 30'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom),
            $urandom,
            $urandom_range(0, 3) != 0);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
